// File: rtl/ec_point_encoder.sv
// SEC1 point serialiser: emits 00, 02/03||X or 04||X||Y one byte per handshake
// from a latched copy of the affine point.
module ec_point_encoder #(
    parameter int unsigned COORD_BYTES = 32,
    localparam int unsigned CNT_W = $clog2(COORD_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*COORD_BYTES-1:0] in_x,
    input  logic [8*COORD_BYTES-1:0] in_y,
    input  logic                     in_compress,
    input  logic                     in_infinity,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_first,
    output logic                     out_last,
    output logic                     busy
);

    typedef enum logic [1:0] {
        StIdle,
        StPrefix,
        StXb,
        StYb
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(COORD_BYTES - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [8*COORD_BYTES-1:0] x_q, x_d;
    logic [8*COORD_BYTES-1:0] y_q, y_d;
    logic                     comp_q, comp_d;
    logic                     inf_q, inf_d;

    logic       xfer;
    logic       cnt_at_last;
    logic [7:0] x_byte;
    logic [7:0] y_byte;

    assign xfer        = out_valid && out_ready;
    assign cnt_at_last = (cnt_q == LastCnt);

    // Byte 0 is the most significant byte of each coordinate.
    always_comb begin
        x_byte = 8'h00;
        y_byte = 8'h00;
        for (int i = 0; i < COORD_BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                x_byte = x_q[8*(COORD_BYTES-1-i) +: 8];
                y_byte = y_q[8*(COORD_BYTES-1-i) +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        comp_d  = comp_q;
        inf_d   = inf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    comp_d  = in_compress;
                    inf_d   = in_infinity;
                    cnt_d   = '0;
                    state_d = StPrefix;
                end
            end
            StPrefix: begin
                if (xfer) begin
                    cnt_d   = '0;
                    state_d = inf_q ? StIdle : StXb;
                end
            end
            StXb: begin
                if (xfer) begin
                    if (cnt_at_last) begin
                        cnt_d   = '0;
                        state_d = comp_q ? StIdle : StYb;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StYb: begin
                if (xfer) begin
                    if (cnt_at_last) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = (state_q != StIdle);
        out_first = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        unique case (state_q)
            StIdle: ;
            StPrefix: begin
                out_first = 1'b1;
                out_last  = inf_q;
                if (inf_q) begin
                    out_data = 8'h00;
                end else if (comp_q) begin
                    out_data = {7'b0000_001, y_q[0]};
                end else begin
                    out_data = 8'h04;
                end
            end
            StXb: begin
                out_data = x_byte;
                out_last = comp_q && cnt_at_last;
            end
            StYb: begin
                out_data = y_byte;
                out_last = cnt_at_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            comp_q  <= 1'b0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            comp_q  <= comp_d;
            inf_q   <= inf_d;
        end
    end

endmodule

// File: tb/tb_ec_point_encoder.sv
// Directed bench for ec_point_encoder: P-256 sized instance for most scenarios,
// P-521 sized instance for the long uncompressed stream.
module tb_ec_point_encoder;

    localparam int unsigned NA = 32;
    localparam int unsigned NB = 66;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic out_ready = 1'b0;

    logic            a_in_valid = 1'b0, a_in_ready;
    logic [8*NA-1:0] a_in_x = '0, a_in_y = '0;
    logic            a_in_compress = 1'b0, a_in_infinity = 1'b0;
    logic            a_out_valid, a_out_first, a_out_last, a_busy;
    logic [7:0]      a_out_data;

    logic            b_in_valid = 1'b0, b_in_ready;
    logic [8*NB-1:0] b_in_x = '0, b_in_y = '0;
    logic            b_in_compress = 1'b0, b_in_infinity = 1'b0;
    logic            b_out_valid, b_out_first, b_out_last, b_busy;
    logic [7:0]      b_out_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_data [0:199];
    logic       got_first[0:199];
    logic       got_last [0:199];
    logic [7:0] exp_data [0:199];
    int n_bytes, n_cycles, stall_err;
    bit cap_done;
    int hs_a = 0;
    int acc_b = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_out_valid && out_ready) hs_a++;
        if (b_in_valid && b_in_ready) acc_b++;
    end

    ec_point_encoder #(.COORD_BYTES(NA)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_x(a_in_x), .in_y(a_in_y),
        .in_compress(a_in_compress), .in_infinity(a_in_infinity),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_first(a_out_first), .out_last(a_out_last), .busy(a_busy)
    );

    ec_point_encoder #(.COORD_BYTES(NB)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_x(b_in_x), .in_y(b_in_y),
        .in_compress(b_in_compress), .in_infinity(b_in_infinity),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_first(b_out_first), .out_last(b_out_last), .busy(b_busy)
    );

    function automatic logic [8*NB-1:0] ramp(input int n, input int base);
        logic [8*NB-1:0] v = '0;
        for (int i = 0; i < n; i++) v[8*(n-1-i) +: 8] = 8'(base + i);
        return v;
    endfunction

    // Present one point at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit sel, input logic [8*NB-1:0] x, input logic [8*NB-1:0] y,
                        input bit comp, input bit inf, input bit hold);
        @(negedge clk);
        if (sel) begin
            b_in_x = x; b_in_y = y; b_in_compress = comp; b_in_infinity = inf; b_in_valid = 1'b1;
        end else begin
            a_in_x = x[8*NA-1:0]; a_in_y = y[8*NA-1:0];
            a_in_compress = comp; a_in_infinity = inf; a_in_valid = 1'b1;
        end
        @(negedge clk);
        a_in_x = ~a_in_x; a_in_y = ~a_in_y; a_in_compress = ~a_in_compress;
        b_in_x = ~b_in_x; b_in_y = ~b_in_y;
        if (!hold) begin
            a_in_valid = 1'b0;
            b_in_valid = 1'b0;
        end
    endtask

    // Records transferred bytes until out_last (or budget); counts stall instability.
    task automatic capture(input bit sel, input bit rnd, input int budget);
        logic pv, pf, pl, cv, cf, cl;
        logic [7:0] pd, cd;
        n_bytes = 0; n_cycles = 0; stall_err = 0; cap_done = 0;
        pv = 0; pf = 0; pl = 0; pd = 0;
        for (int c = 0; c < budget && !cap_done; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cv = sel ? b_out_valid : a_out_valid;
            cd = sel ? b_out_data : a_out_data;
            cf = sel ? b_out_first : a_out_first;
            cl = sel ? b_out_last : a_out_last;
            if (pv && (!cv || cd !== pd || cf !== pf || cl !== pl)) stall_err++;
            n_cycles++;
            if (cv && out_ready && n_bytes < 200) begin
                got_data[n_bytes] = cd; got_first[n_bytes] = cf; got_last[n_bytes] = cl;
                n_bytes++;
                if (cl) begin
                    cap_done = 1;
                    a_in_valid = 1'b0;
                    b_in_valid = 1'b0;
                end
            end
            pv = cv && !out_ready; pd = cd; pf = cf; pl = cl;
            @(negedge clk);
        end
    endtask

    task automatic check_stream(input string name, input int n);
        total++;
        if (!cap_done || n_bytes !== n) begin
            bad++;
            $display("FAIL %s length: got %0d bytes (done=%0d) want %0d", name, n_bytes,
                     cap_done, n);
        end
        for (int i = 0; i < n && i < n_bytes; i++) begin
            total++;
            if (got_data[i] !== exp_data[i] || got_first[i] !== (i == 0) ||
                got_last[i] !== (i == n - 1)) begin
                bad++;
                $display("FAIL %s byte %0d: got %02h f=%0d l=%0d want %02h f=%0d l=%0d", name, i,
                         got_data[i], got_first[i], got_last[i], exp_data[i], i == 0, i == n - 1);
            end
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (a_out_valid !== 0 || a_in_ready !== 1 || a_busy !== 0 || a_out_data !== 8'h00 ||
            a_out_first !== 0 || a_out_last !== 0) begin
            bad++;
            $display("FAIL reset: valid=%0d ready=%0d busy=%0d data=%02h f=%0d l=%0d want 0 1 0 00 0 0",
                     a_out_valid, a_in_ready, a_busy, a_out_data, a_out_first, a_out_last);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_uncompressed;
        exp_data[0] = 8'h04;
        for (int i = 0; i < 32; i++) exp_data[1 + i] = 8'(8'h01 + i);
        for (int i = 0; i < 32; i++) exp_data[33 + i] = 8'(8'h21 + i);
        send(0, ramp(32, 8'h01), ramp(32, 8'h21), 0, 0, 0);
        total++;
        if (a_out_valid !== 1 || a_out_first !== 1 || a_in_ready !== 0 || a_busy !== 1) begin
            bad++;
            $display("FAIL latency: valid=%0d first=%0d ready=%0d busy=%0d want 1 1 0 1",
                     a_out_valid, a_out_first, a_in_ready, a_busy);
        end
        capture(0, 0, 200);
        check_stream("uncompressed", 65);
        total++;
        if (n_cycles !== 65) begin
            bad++;
            $display("FAIL uncompressed cycles: got %0d want 65", n_cycles);
        end
        total++;
        if (a_out_valid !== 0 || a_in_ready !== 1 || a_busy !== 0) begin
            bad++;
            $display("FAIL uncompressed idle: valid=%0d ready=%0d busy=%0d want 0 1 0",
                     a_out_valid, a_in_ready, a_busy);
        end
    endtask

    task automatic test_compressed;
        logic [8*NB-1:0] xa;
        xa = '0;
        for (int i = 0; i < 32; i++) xa[8*i +: 8] = 8'hAA;
        for (int i = 0; i < 32; i++) exp_data[1 + i] = 8'hAA;
        exp_data[0] = 8'h03;
        send(0, xa, {{(8*NB-8){1'b0}}, 8'h5B}, 1, 0, 0);
        capture(0, 0, 100);
        check_stream("compressed_odd", 33);
        exp_data[0] = 8'h02;
        send(0, xa, {{(8*NB-8){1'b0}}, 8'h5A}, 1, 0, 0);
        capture(0, 0, 100);
        check_stream("compressed_even", 33);
    endtask

    task automatic test_infinity;
        send(0, ramp(32, 8'h01), ramp(32, 8'h21), 1, 1, 0);
        total++;
        if (a_out_valid !== 1 || a_out_data !== 8'h00 || a_out_first !== 1 ||
            a_out_last !== 1 || a_in_ready !== 0) begin
            bad++;
            $display("FAIL infinity byte: valid=%0d data=%02h f=%0d l=%0d ready=%0d want 1 00 1 1 0",
                     a_out_valid, a_out_data, a_out_first, a_out_last, a_in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (a_in_ready !== 1 || a_out_valid !== 0 || a_busy !== 0) begin
            bad++;
            $display("FAIL infinity return: ready=%0d valid=%0d busy=%0d want 1 0 0",
                     a_in_ready, a_out_valid, a_busy);
        end
    endtask

    task automatic test_backpressure;
        int hs0;
        exp_data[0] = 8'h04;
        for (int i = 0; i < 32; i++) exp_data[1 + i] = 8'(8'h01 + i);
        for (int i = 0; i < 32; i++) exp_data[33 + i] = 8'(8'h21 + i);
        out_ready = 1'b0;
        hs0 = hs_a;
        send(0, ramp(32, 8'h01), ramp(32, 8'h21), 0, 0, 0);
        capture(0, 1, 2000);
        out_ready = 1'b1;
        @(negedge clk);
        check_stream("backpressure", 65);
        total++;
        if (stall_err !== 0) begin
            bad++;
            $display("FAIL backpressure stability: got %0d unstable stalls want 0", stall_err);
        end
        total++;
        if (hs_a - hs0 !== 65) begin
            bad++;
            $display("FAIL backpressure handshakes: got %0d want 65", hs_a - hs0);
        end
    endtask

    task automatic test_reset_abort;
        send(0, ramp(32, 8'h01), ramp(32, 8'h21), 0, 0, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) @(negedge clk);
        total++;
        if (a_out_data !== 8'h0A) begin
            bad++;
            $display("FAIL abort position: got %02h want 0a", a_out_data);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (a_out_valid !== 0 || a_in_ready !== 1 || a_busy !== 0 || a_out_last !== 0) begin
            bad++;
            $display("FAIL abort outputs: valid=%0d ready=%0d busy=%0d last=%0d want 0 1 0 0",
                     a_out_valid, a_in_ready, a_busy, a_out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_data[0] = 8'h03;
        for (int i = 0; i < 32; i++) exp_data[1 + i] = 8'(8'h01 + i);
        send(0, ramp(32, 8'h01), {{(8*NB-8){1'b0}}, 8'h01}, 1, 0, 0);
        capture(0, 0, 100);
        check_stream("after_abort", 33);
    endtask

    task automatic test_wide_p521;
        int acc0;
        exp_data[0] = 8'h04;
        for (int i = 0; i < 66; i++) exp_data[1 + i] = 8'(8'h01 + i);
        for (int i = 0; i < 66; i++) exp_data[67 + i] = 8'(8'h80 + i);
        acc0 = acc_b;
        send(1, ramp(66, 8'h01), ramp(66, 8'h80), 0, 0, 1);
        capture(1, 0, 300);
        check_stream("p521", 133);
        total++;
        if (acc_b - acc0 !== 1) begin
            bad++;
            $display("FAIL p521 acceptances: got %0d want 1", acc_b - acc0);
        end
        total++;
        if (b_in_ready !== 1 || b_out_valid !== 0) begin
            bad++;
            $display("FAIL p521 idle: ready=%0d valid=%0d want 1 0", b_in_ready, b_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_uncompressed();
        test_compressed();
        test_infinity();
        test_backpressure();
        test_reset_abort();
        test_wide_p521();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
